seg7_scan_decoder: RTL

// Receive side of the seven-segment display interface: watches a multiplexed segment bus
// (one shared SEG bus plus a one-hot digit strobe) and recovers the BCD digit shown on each position.
// A digit is captured only after SEG/SEL have been stable for a programmable time.
// A valid/ack handshake presents a full frame of NUM_DIGITS digits.

---
 rtl/seg7_scan_decoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan receiver.
// Watches a multiplexed segment bus (shared seg bus plus a one-hot digit strobe)
// and rebuilds a frame of BCD digits. A digit is taken only after seg/sel have
// held steady long enough. The finished frame is presented with a valid/ack
// handshake.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:6]              seg,
  input  logic [NUM_DIGITS-1:0]   sel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   bad,
  output logic                    valid,
  input  logic                    ack,
  output logic                    sel_err,
  output logic                    overrun
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } frame_state_e;

  // seg is indexed a..g from bit 0, so the literals below read a..g left to right.
  // Result is {illegal, nibble}.
  function automatic logic [4:0] decode_seg(input logic [0:6] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = {1'b0, 4'd0};
      7'b0110000: r = {1'b0, 4'd1};
      7'b1101101: r = {1'b0, 4'd2};
      7'b1111001: r = {1'b0, 4'd3};
      7'b0110011: r = {1'b0, 4'd4};
      7'b1011011: r = {1'b0, 4'd5};
      7'b1011111: r = {1'b0, 4'd6};
      7'b1110000: r = {1'b0, 4'd7};
      7'b1111111: r = {1'b0, 4'd8};
      7'b1111011: r = {1'b0, 4'd9};
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  logic [0:6]              seg_r;
  logic [0:6]              seg_prev_r;
  logic [NUM_DIGITS-1:0]   sel_r;
  logic [NUM_DIGITS-1:0]   sel_prev_r;
  logic [7:0]              cnt_r;
  logic [7:0]              cnt_nxt_s;
  logic                    capture_s;
  logic [3:0]              ones_s;
  logic                    onehot_s;
  logic                    multihot_s;
  logic [4:0]              dec_s;

  logic [4*NUM_DIGITS-1:0] shadow_digits_r;
  logic [4*NUM_DIGITS-1:0] shadow_digits_nxt_s;
  logic [NUM_DIGITS-1:0]   shadow_bad_r;
  logic [NUM_DIGITS-1:0]   shadow_bad_nxt_s;
  logic [NUM_DIGITS-1:0]   mask_r;
  logic [NUM_DIGITS-1:0]   mask_nxt_s;
  logic                    complete_s;

  frame_state_e            state_r;
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   bad_r;
  logic                    valid_r;
  logic                    sel_err_r;
  logic                    overrun_r;

  assign digits  = digits_r;
  assign bad     = bad_r;
  assign valid   = valid_r;
  assign sel_err = sel_err_r;
  assign overrun = overrun_r;

  // Register the bus once, keep the previous sample, and track how long it has held.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r      <= 7'b0000000;
      seg_prev_r <= 7'b0000000;
      sel_r      <= '0;
      sel_prev_r <= '0;
      cnt_r      <= 8'd0;
    end else begin
      seg_r      <= seg;
      seg_prev_r <= seg_r;
      sel_r      <= sel;
      sel_prev_r <= sel_r;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // Stability counter and capture strobe: capture once, on the cycle the count first hits its top.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if ((seg_r != seg_prev_r) || (sel_r != sel_prev_r)) begin
      cnt_nxt_s = 8'd0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + 8'd1;
    end
    capture_s = (cnt_nxt_s == CNT_MAX) && (cnt_r != CNT_MAX);
  end

  // Classify the strobe (blank / one-hot / multi-hot) and decode the segment pattern.
  always_comb begin
    ones_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ones_s = ones_s + 4'(sel_r[i]);
    end
    onehot_s   = (ones_s == 4'd1);
    multihot_s = (ones_s > 4'd1);
    dec_s      = decode_seg(seg_r);
  end

  // Shadow frame update: a one-hot capture writes its position and marks it in the mask.
  always_comb begin
    shadow_digits_nxt_s = shadow_digits_r;
    shadow_bad_nxt_s    = shadow_bad_r;
    mask_nxt_s          = mask_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      shadow_digits_nxt_s[4*i +: 4] = (capture_s && onehot_s && sel_r[i]) ? dec_s[3:0]
                                                                          : shadow_digits_r[4*i +: 4];
      shadow_bad_nxt_s[i] = (capture_s && onehot_s && sel_r[i]) ? dec_s[4] : shadow_bad_r[i];
      mask_nxt_s[i]       = (capture_s && onehot_s && sel_r[i]) ? 1'b1 : mask_r[i];
    end
    complete_s = &mask_nxt_s;
  end

  // Frame FSM: publish completed frames, hold them until ack, flag frames lost while holding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= COLLECT;
      digits_r        <= '0;
      bad_r           <= '0;
      valid_r         <= 1'b0;
      sel_err_r       <= 1'b0;
      overrun_r       <= 1'b0;
      mask_r          <= '0;
      shadow_bad_r    <= '0;
      shadow_digits_r <= '0;
    end else begin
      sel_err_r       <= capture_s && multihot_s;
      shadow_digits_r <= shadow_digits_nxt_s;
      if (complete_s) begin
        mask_r       <= '0;
        shadow_bad_r <= '0;
        // An ack in the same cycle frees the output register for the new frame.
        if ((state_r == COLLECT) || ack) begin
          digits_r <= shadow_digits_nxt_s;
          bad_r    <= shadow_bad_nxt_s;
          valid_r  <= 1'b1;
          state_r  <= HOLD;
        end else begin
          overrun_r <= 1'b1;
        end
      end else begin
        mask_r       <= mask_nxt_s;
        shadow_bad_r <= shadow_bad_nxt_s;
        if ((state_r == HOLD) && ack) begin
          valid_r <= 1'b0;
          state_r <= COLLECT;
        end else begin
          valid_r <= valid_r;
          state_r <= state_r;
        end
      end
    end
  end

endmodule
